// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic controller blocks.
package traffic_pkg;

  // Manual-override interlock states.
  typedef enum logic [1:0] {
    M_OFF  = 2'd0,
    M_A_GO = 2'd1,
    M_B_GO = 2'd2,
    M_GAP  = 2'd3
  } manual_state_t;

  // Default timing for the manual switch conditioner.
  localparam int MAN_DEBOUNCE_CYCLES = 500_000;
  localparam int MAN_GAP_CYCLES      = 50_000_000;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw switch.
// The accepted level flips only after the synchronised value has disagreed
// with it for DEBOUNCE_CYCLES consecutive edges; one agreeing cycle restarts
// the count.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous switch into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreements; flip on the last one. The count stops at
  // LAST and is cleared on the flip, so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign level = r_level;

endmodule

// File: rtl/manual_switch_conditioner.sv
// Conditions the two manual-override switches: each is debounced, the pair is
// interlocked so at most one go request is presented, and every handover
// passes through a timed all-off gap. All outputs are registered.
module manual_switch_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MAN_DEBOUNCE_CYCLES,
  parameter int GAP_CYCLES      = MAN_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw1_raw,
  input  logic sw2_raw,
  output logic sw1,
  output logic sw2,
  output logic gap_active,
  output logic conflict
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic w_a_db;
  logic w_b_db;
  logic w_req_a;
  logic w_req_b;

  manual_state_t r_state;
  logic [GW-1:0] r_gap_cnt;
  logic          r_sw1;
  logic          r_sw2;
  logic          r_gap;
  logic          r_conflict;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw1_raw),
    .level (w_a_db)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw2_raw),
    .level (w_b_db)
  );

  // Both switches high is treated as no request at all.
  assign w_req_a = w_a_db & ~w_b_db;
  assign w_req_b = w_b_db & ~w_a_db;

  // Interlock FSM; the Moore outputs are registered alongside the next state
  // so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= M_OFF;
      r_gap_cnt  <= '0;
      r_sw1      <= 1'b0;
      r_sw2      <= 1'b0;
      r_gap      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_a_db & w_b_db;
      case (r_state)
        M_OFF: begin
          // Lamps are already dark, so a request goes straight to GO.
          if (w_req_a) begin
            r_state <= M_A_GO;
            r_sw1   <= 1'b1;
          end else if (w_req_b) begin
            r_state <= M_B_GO;
            r_sw2   <= 1'b1;
          end
        end
        M_A_GO: begin
          // Release, conflict and swap all leave through the gap.
          if (!w_req_a) begin
            r_state   <= M_GAP;
            r_gap_cnt <= GAP_LOAD;
            r_sw1     <= 1'b0;
            r_gap     <= 1'b1;
          end
        end
        M_B_GO: begin
          if (!w_req_b) begin
            r_state   <= M_GAP;
            r_gap_cnt <= GAP_LOAD;
            r_sw2     <= 1'b0;
            r_gap     <= 1'b1;
          end
        end
        M_GAP: begin
          // Fixed length; requests are only looked at on the last cycle.
          if (r_gap_cnt == '0) begin
            r_gap <= 1'b0;
            if (w_req_a) begin
              r_state <= M_A_GO;
              r_sw1   <= 1'b1;
            end else if (w_req_b) begin
              r_state <= M_B_GO;
              r_sw2   <= 1'b1;
            end else begin
              r_state <= M_OFF;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_state <= M_OFF;
          r_sw1   <= 1'b0;
          r_sw2   <= 1'b0;
          r_gap   <= 1'b0;
        end
      endcase
    end
  end

  assign sw1        = r_sw1;
  assign sw2        = r_sw2;
  assign gap_active = r_gap;
  assign conflict   = r_conflict;

endmodule

// File: tb/tb_manual_switch_conditioner.sv
// Bench for manual_switch_conditioner with DEBOUNCE_CYCLES=4, GAP_CYCLES=3.
// Output vector layout is {sw1, sw2, gap_active, conflict}. A raw change
// driven on the negedge after edge c is first sampled at edge c+1 (E0);
// debounced levels flip at E5 and outputs react at E6, i.e. edge c+7.
module tb_manual_switch_conditioner;

  localparam int DB  = 4;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst;
  logic sw1_raw;
  logic sw2_raw;
  logic sw1;
  logic sw2;
  logic gap_active;
  logic conflict;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [3:0] prev = 4'b0000;
  bit         mon_en = 1'b0;

  manual_switch_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw1_raw    (sw1_raw),
    .sw2_raw    (sw2_raw),
    .sw1        (sw1),
    .sw2        (sw2),
    .gap_active (gap_active),
    .conflict   (conflict)
  );

  // Clock and edge counter: cyc equals the index of the most recent posedge.
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect the output vector to change to v at edge 'at'.
  task automatic push(input int at, input logic [3:0] v);
    exp_q.push_back(v);
    exp_cyc_q.push_back(at);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: on every output change pop the next expectation and compare
  // both the new value and the edge it appeared on.
  initial begin
    logic [3:0] cur;
    logic [3:0] ev;
    int         ec;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {sw1, sw2, gap_active, conflict};
        n_checks++;
        if (sw1 & sw2) begin
          n_err++;
          $display("FAIL interlock: sw1=%b sw2=%b at edge %0d", sw1, sw2, cyc);
        end
        if (cur !== prev) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change: got %b from %b at edge %0d, none expected", cur, prev, cyc);
          end else begin
            ev = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (cur !== ev || cyc != ec) begin
              n_err++;
              $display("FAIL output_change: got %b at edge %0d expected %b at edge %0d", cur, cyc, ev, ec);
            end
          end
          prev = cur;
        end
      end
    end
  end

  // Driver: directed scenarios with hand-computed change edges.
  initial begin
    int c;
    rst     = 1'b1;
    sw1_raw = 1'b1;
    sw2_raw = 1'b1;

    // Reset held with both raws high: outputs stay 0.
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", {sw1, sw2, gap_active, conflict}, 4'b0000);
    end
    rst    = 1'b0;
    prev   = 4'b0000;
    mon_en = 1'b1;
    c = cyc;
    push(c + 7, 4'b0001);        // conflict only, no go output
    wait_cyc(12);
    c = cyc;
    sw1_raw = 1'b0;
    sw2_raw = 1'b0;
    push(c + 7, 4'b0000);
    wait_cyc(12);

    // Bounce rejection: 2-cycle pulses never pass, then a steady press does.
    for (int i = 0; i < 10; i++) begin
      sw1_raw = (i % 2 == 0);
      wait_cyc(2);
    end
    sw1_raw = 1'b1;
    c = cyc;
    push(c + 7, 4'b1000);
    wait_cyc(14);

    // Swap A to B on one edge: GO -> GAP(3) -> other GO.
    c = cyc;
    sw1_raw = 1'b0;
    sw2_raw = 1'b1;
    push(c + 7,  4'b0010);
    push(c + 10, 4'b0100);
    wait_cyc(14);

    // Swap back B to A.
    c = cyc;
    sw1_raw = 1'b1;
    sw2_raw = 1'b0;
    push(c + 7,  4'b0010);
    push(c + 10, 4'b1000);
    wait_cyc(14);

    // Conflict from A_GO: gap, then OFF while conflict persists.
    c = cyc;
    sw2_raw = 1'b1;
    push(c + 7,  4'b0011);
    push(c + 10, 4'b0001);
    wait_cyc(14);
    c = cyc;
    sw2_raw = 1'b0;
    push(c + 7, 4'b1000);
    wait_cyc(14);

    // B request arrives mid-gap: gap keeps its length, B follows directly.
    c = cyc;
    sw1_raw = 1'b0;
    push(c + 7,  4'b0010);
    push(c + 10, 4'b0100);
    wait_cyc(2);
    sw2_raw = 1'b1;
    wait_cyc(14);

    // B released and re-pressed: its level is back only after the last gap
    // cycle, so the gap is not extended and the FSM passes through OFF.
    c = cyc;
    sw2_raw = 1'b0;
    push(c + 7,  4'b0010);
    push(c + 10, 4'b0000);
    push(c + 11, 4'b0100);
    wait_cyc(4);
    sw2_raw = 1'b1;
    wait_cyc(14);

    // Reset on gap cycle 2: everything drops on that edge, no residual gap.
    c = cyc;
    sw2_raw = 1'b0;
    push(c + 7, 4'b0010);
    push(c + 8, 4'b0000);
    wait_cyc(7);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(20);
    chk("post_reset_idle", {sw1, sw2, gap_active, conflict}, 4'b0000);

    // Every expected change must have been observed within the run.
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending changes expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/manual_switch_conditioner.md
# manual_switch_conditioner

Conditions the two raw manual-override switches (lane A go, lane B go) before they reach the manual-mode lamp decoder. Each switch is synchronised and debounced, and the pair is interlocked: at most one go request is ever presented, and every handover passes through a timed all-off gap. Outputs `sw1`/`sw2` drive the decoder's `sw1`/`sw2` inputs directly.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles required to accept a level change. Must be ≥1.
- `GAP_CYCLES`, default 50_000_000: length of the all-off interlock gap, in cycles. Must be ≥1.

**Ports**
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `sw1_raw` in 1: asynchronous, bouncy lane-A switch.
- `sw2_raw` in 1: asynchronous, bouncy lane-B switch.
- `sw1` out 1: clean lane-A go request to the decoder. Registered.
- `sw2` out 1: clean lane-B go request to the decoder. Registered.
- `gap_active` out 1: interlock gap in progress. Registered.
- `conflict` out 1: both debounced switches are high. Registered.

## Operation

- **Per channel**
  - 2-FF synchroniser, then debouncer.
  - The debounced level flips only after the synchronised value has differed from it for `DEBOUNCE_CYCLES` consecutive edges.
  - Any cycle with agreement clears the counter to 0.
- **Requests**
  - `req_a = a_db & ~b_db`
  - `req_b = b_db & ~a_db`
  - Both high counts as no request; `conflict` = 1.
- **FSM states:** M_OFF, M_A_GO, M_B_GO, M_GAP. Outputs are Moore and registered:
  - `sw1` = (state == M_A_GO)
  - `sw2` = (state == M_B_GO)
  - `gap_active` = (state == M_GAP)
- **Transitions**
  - M_OFF: `req_a` → M_A_GO. `req_b` → M_B_GO. Otherwise stay. No gap is needed here because the lamps are already dark.
  - M_A_GO: `!req_a` → M_GAP. This covers release, conflict and a swap to B.
  - M_B_GO: `!req_b` → M_GAP.
  - M_GAP: stays exactly `GAP_CYCLES` cycles. Request changes during the gap neither shorten nor extend it.
  - On the last gap cycle, requests are evaluated: `req_a` → M_A_GO, `req_b` → M_B_GO, otherwise M_OFF.
- **Invariant:** `sw1 & sw2` is never 1.
- **Widths:**
  - Counters are `$clog2(N+1)` bits.
  - The gap counter loads `GAP_CYCLES-1` on entry and decrements to 0.
  - The debounce counter saturates and never wraps.

## Timing

- **Reset values:** `sw1`=0, `sw2`=0, `gap_active`=0, `conflict`=0. Synchroniser flops, debounced levels and counters are all 0. State is M_OFF.
- **Reset mid-operation:**
  - Every output returns to 0 on the reset edge, including from M_GAP or M_A_GO.
  - Raw inputs held high through reset are debounced again with full latency after reset deasserts.
- **Latency:** edge E0 is the first edge that samples a new raw level.
  - Synchroniser output changes at E1.
  - Debounced level flips at E(`DEBOUNCE_CYCLES`+1).
  - FSM outputs react at E(`DEBOUNCE_CYCLES`+2).
  - `conflict` follows the debounced levels one edge later, also at E(`DEBOUNCE_CYCLES`+2).
- **Gap timing:** `gap_active` is high for exactly `GAP_CYCLES` cycles. The new go output asserts on the edge where `gap_active` falls, with no idle cycle between them.
- **Simultaneous events:**
  - A and B flipping in the same cycle (swap) gives GO → GAP → other GO.
  - A request arriving on the gap's last cycle is honoured.
  - A request dropping on that cycle sends the FSM to M_OFF.

## Structure

- **Shared package `traffic_pkg`:**
  - `manual_state_t` enum (M_OFF, M_A_GO, M_B_GO, M_GAP).
  - Default constants `MAN_DEBOUNCE_CYCLES` and `MAN_GAP_CYCLES`.
- **Sub-module `switch_debounce`:**
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `clk`, `rst`, `raw`, `level`.
  - Contains the synchroniser and counter; instantiated twice.
- **Top level:** FSM, gap counter and output registers.

## Test plan

All scenarios run with `DEBOUNCE_CYCLES`=4 and `GAP_CYCLES`=3.

1. **Reset with raw inputs high:**
   - Hold `rst`=1 for 2 cycles with `sw1_raw`=`sw2_raw`=1 → all outputs 0 during reset.
   - After release, `sw1`=`sw2`=0 and `conflict` rises 6 edges after the first post-reset sampling edge.
2. **Bounce rejection:**
   - Toggle `sw1_raw` every 2 cycles for 20 cycles, then hold 1 → `sw1` stays 0 throughout the bouncing.
   - `sw1` rises 6 edges after the final transition. `gap_active` never asserts.
3. **Swap A→B:**
   - With `sw1`=1, set `sw1_raw`=0 and `sw2_raw`=1 on the same edge E0.
   - At E6: `sw1`=0, `gap_active`=1 for 3 cycles.
   - At E9: `gap_active`=0, `sw2`=1. `sw1&sw2` is never 1.
4. **Conflict:** from `sw1`=1, raise `sw2_raw` → `conflict`=1 and M_GAP for 3 cycles, then M_OFF with `sw1`=`sw2`=0.
5. **Gap not shortened:**
   - Release A, then re-press A so its debounced level returns mid-gap → gap still lasts 3 cycles.
   - Then `sw1`=1 with no intervening M_OFF cycle.
6. **Reset mid-gap:** assert `rst` on gap cycle 2 → outputs 0 on that edge. After release with raws low, state stays M_OFF and no residual gap occurs.
